inst_fetch_queue: RTL and testbench

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

---
 rtl/inst_fetch_queue_pkg.sv | 18 +
 rtl/inst_fetch_queue_if.sv | 27 ++
 rtl/inst_fetch_queue_sync_fifo.sv | 56 +++++
 rtl/inst_fetch_queue.sv | 81 ++++++++
 tb/tb_inst_fetch_queue.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared widths, FSM state encoding and address helper for the instruction fetch queue.
package inst_fetch_queue_pkg;

    localparam int ADDR_LEN  = 32;
    localparam int INSTR_LEN = 32;
    localparam int ENTRY_W   = INSTR_LEN + ADDR_LEN;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } fetch_state_e;

    function automatic logic [ADDR_LEN-1:0] align_word(input logic [ADDR_LEN-1:0] a);
        return a & ~ADDR_LEN'(3);
    endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Instruction-memory request/response and decode-side handshake bundle.
interface inst_fetch_queue_if;
    import inst_fetch_queue_pkg::*;

    logic                 imem_req;
    logic [ADDR_LEN-1:0]  imem_addr;
    logic                 imem_ready;
    logic                 imem_rvalid;
    logic [INSTR_LEN-1:0] imem_rdata;
    logic                 out_valid;
    logic [INSTR_LEN-1:0] out_inst;
    logic [ADDR_LEN-1:0]  out_pc_plus_4;
    logic                 out_ready;
    logic                 redirect;
    logic [ADDR_LEN-1:0]  redirect_pc;

    modport master (
        output imem_req, imem_addr, out_valid, out_inst, out_pc_plus_4,
        input  imem_ready, imem_rvalid, imem_rdata, out_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_inst, out_pc_plus_4,
        output imem_ready, imem_rvalid, imem_rdata, out_ready, redirect, redirect_pc
    );

endinterface

// File: rtl/inst_fetch_queue_sync_fifo.sv
// Power-of-two synchronous FIFO with flush; head reads as zero when empty.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch engine: single-outstanding imem requester feeding a small queue toward IF/ID,
// with redirect flush and stale-response discard.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int                  DEPTH    = 4,
    parameter logic [ADDR_LEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    inst_fetch_queue_if.master  bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e        state_q, state_d;
    logic [ADDR_LEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_LEN-1:0] issued_pc_q, issued_pc_d;
    logic                hs, push, pop, full, empty;
    logic [CW-1:0]       count;
    logic [ENTRY_W-1:0]  head;

    // Gating with rst keeps the request low while reset is held.
    assign bus.imem_req  = !rst && (state_q == S_IDLE) && !full && !bus.redirect;
    assign bus.imem_addr = fetch_pc_q;
    assign hs            = bus.imem_req && bus.imem_ready;

    assign push = (state_q == S_WAIT) && bus.imem_rvalid && !bus.redirect;
    assign pop  = !empty && bus.out_ready && !bus.redirect;

    assign bus.out_valid                       = (count != '0);
    assign {bus.out_inst, bus.out_pc_plus_4}   = head;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        issued_pc_d = issued_pc_q;
        if (hs) begin
            fetch_pc_d  = fetch_pc_q + ADDR_LEN'(4);
            issued_pc_d = fetch_pc_q;
        end
        case (state_q)
            S_IDLE:    if (hs) state_d = S_WAIT;
            S_WAIT: begin
                if (bus.imem_rvalid)   state_d = S_IDLE;
                else if (bus.redirect) state_d = S_DISCARD;
            end
            S_DISCARD: if (bus.imem_rvalid) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (bus.redirect) fetch_pc_d = align_word(bus.redirect_pc);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            fetch_pc_q  <= RESET_PC;
            issued_pc_q <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            issued_pc_q <= issued_pc_d;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (bus.redirect),
        .din   ({bus.imem_rdata, issued_pc_q + ADDR_LEN'(4)}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomised bench: driver plays instruction memory and keeps a queue model of expected
// heads; a negedge monitor pops and compares whatever the fetch queue presents.
module tb_inst_fetch_queue;
    import inst_fetch_queue_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;

    inst_fetch_queue_if ifc();

    inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] exp_q[$];
    bit          outstanding, stale, mon_en;
    logic [31:0] model_pc, iss_addr;
    int          resp_left, hs_count, same_hit;

    int p_ready = 100, p_oready = 100, p_redir = 0, p_stray = 0, fix_delay = 1;
    int redir_mode = 0;  // 0 random, 1 WAIT without rvalid, 2 rvalid+pop, 3 immediate
    bit have_pc = 0;
    logic [31:0] forced_pc;

    bit          ev_hs, ev_resp, ev_push, ev_redir;
    logic [31:0] ev_hs_addr, ev_rp;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_events();
        if (ev_redir) exp_q.delete();
        if (ev_push)  exp_q.push_back({mem_word(iss_addr), iss_addr + 32'd4});
        if (ev_resp)  outstanding = 0;
        if (ev_hs) begin
            iss_addr    = model_pc;
            model_pc    = model_pc + 32'd4;
            outstanding = 1;
            stale       = 0;
            resp_left   = (fix_delay != 0) ? fix_delay : int'($urandom_range(1, 3));
            hs_count++;
        end else if (outstanding) begin
            resp_left--;
        end
        if (ev_redir) begin
            model_pc = ev_rp & ~32'h3;
            if (outstanding) stale = 1;
        end
        {ev_hs, ev_resp, ev_push, ev_redir} = '0;
    endtask

    task automatic drive_inputs();
        bit rv, st, do_r;
        rv = outstanding && (resp_left == 1);
        st = !outstanding && (int'($urandom_range(99)) < p_stray);
        ifc.imem_rvalid = rv || st;
        ifc.imem_rdata  = rv ? mem_word(iss_addr) : $urandom;
        ifc.imem_ready  = int'($urandom_range(99)) < p_ready;
        ifc.out_ready   = int'($urandom_range(99)) < p_oready;
        case (redir_mode)
            1:       do_r = outstanding && !rv;
            2:       do_r = rv && !stale && ifc.out_valid && ifc.out_ready;
            3:       do_r = 1;
            default: do_r = int'($urandom_range(99)) < p_redir;
        endcase
        ifc.redirect = do_r;
        if (do_r) begin
            if (have_pc) ifc.redirect_pc = forced_pc;
            else case ($urandom_range(2))
                0:       ifc.redirect_pc = 32'h0000_0040;
                1:       ifc.redirect_pc = 32'hFFFF_FFF8;
                default: ifc.redirect_pc = $urandom;
            endcase
            if (redir_mode == 2) same_hit++;
            have_pc    = 0;
            redir_mode = 0;
        end else begin
            ifc.redirect_pc = $urandom;
        end
    endtask

    task automatic sample_events();
        if (rst) begin
            {ev_hs, ev_resp, ev_push, ev_redir} = '0;
            return;
        end
        ev_hs      = ifc.imem_req && ifc.imem_ready;
        ev_hs_addr = ifc.imem_addr;
        if (ev_hs) check("hs_addr", ifc.imem_addr, model_pc);
        ev_resp  = ifc.imem_rvalid && outstanding;
        ev_push  = ev_resp && !stale && !ifc.redirect;
        ev_redir = ifc.redirect;
        ev_rp    = ifc.redirect_pc;
    endtask

    task automatic step();
        apply_events();
        drive_inputs();
        @(negedge clk);
        sample_events();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_redir(input string name);
        for (int i = 0; i < 100 && redir_mode != 0; i++) step();
        if (redir_mode != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: redirect window never occurred", name);
            redir_mode = 0;
            have_pc    = 0;
        end
    endtask

    task automatic wait_hs(input string name, input logic [31:0] exp);
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            got = ev_hs;
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no handshake within 40 cycles", name);
        end else begin
            check(name, ev_hs_addr, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, ifc.out_valid, 0);
        check({tag, "_imem_req"},  ifc.imem_req, 0);
        check({tag, "_out_inst"},  ifc.out_inst, 0);
        check({tag, "_out_pc4"},   ifc.out_pc_plus_4, 0);
        check({tag, "_imem_addr"}, ifc.imem_addr, RESET_PC);
    endtask

    task automatic model_reset();
        exp_q.delete();
        outstanding = 0;
        stale       = 0;
        model_pc    = RESET_PC;
        resp_left   = 0;
        {ev_hs, ev_resp, ev_push, ev_redir} = '0;
    endtask

    // Monitor: compares presented outputs with the model and retires consumed heads.
    always @(negedge clk) begin : mon
        logic [63:0] h;
        logic        exp_req;
        if (mon_en && !rst) begin
            exp_req = !outstanding && (exp_q.size() < DEPTH) && !ifc.redirect;
            check("imem_req", ifc.imem_req, exp_req);
            check("out_valid", ifc.out_valid, exp_q.size() != 0);
            if (ifc.out_valid && exp_q.size() != 0) begin
                h = exp_q[0];
                check("out_inst", ifc.out_inst, h[63:32]);
                check("out_pc4", ifc.out_pc_plus_4, h[31:0]);
                if (ifc.out_ready && !ifc.redirect) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0;
        ifc.imem_ready = 0; ifc.imem_rvalid = 0; ifc.imem_rdata = '0;
        ifc.out_ready = 0; ifc.redirect = 0; ifc.redirect_pc = '0;
        mon_en = 0; hs_count = 0; same_hit = 0;
        model_reset();
        #1 rst = 1;
        #1 check_reset_outputs("por");
        @(posedge clk); @(posedge clk); #1;
        rst = 0;
        mon_en = 1;

        // streaming from reset
        wait_hs("stream_a0", 32'h0);
        wait_hs("stream_a4", 32'h4);
        wait_hs("stream_a8", 32'h8);
        repeat (25) step();

        // fill with decode stalled, then a single pop
        p_ready = 0; p_oready = 100;
        repeat (10) step();
        p_ready = 100; p_oready = 0;
        h0 = hs_count;
        repeat (20) step();
        check("fill_hs", hs_count - h0, DEPTH);
        check("fill_req_low", ifc.imem_req, 0);
        p_oready = 100;
        step();
        p_oready = 0;
        repeat (10) step();
        check("fill_pop_hs", hs_count - h0, DEPTH + 1);

        // redirect in WAIT, stale response dropped
        p_oready = 100; fix_delay = 3;
        redir_mode = 1; have_pc = 1; forced_pc = 32'h40;
        wait_redir("redir_wait");
        wait_hs("redir_wait_addr", 32'h40);

        // address wrap and unaligned target
        fix_delay = 1;
        redir_mode = 3; have_pc = 1; forced_pc = 32'hFFFF_FFFC;
        wait_redir("redir_wrap");
        wait_hs("wrap_addr", 32'hFFFF_FFFC);
        wait_hs("wrap_next", 32'h0);
        repeat (4) step();
        redir_mode = 3; have_pc = 1; forced_pc = 32'h13;
        wait_redir("redir_unal");
        wait_hs("unaligned_addr", 32'h10);

        // redirect + rvalid + pop in one cycle
        fix_delay = 0; p_oready = 40; p_ready = 100;
        redir_mode = 2; have_pc = 1; forced_pc = 32'h200;
        wait_redir("same_cycle");
        check("same_cycle_hit", same_hit, 1);
        ifc.redirect = 0;
        #1;
        check("same_out_valid", ifc.out_valid, 0);
        check("same_imem_req", ifc.imem_req, 1);
        check("same_imem_addr", ifc.imem_addr, 32'h200);

        // random soak
        p_ready = 70; p_oready = 60; p_redir = 5; p_stray = 10; fix_delay = 0;
        repeat (1500) step();

        // async reset while discarding
        p_redir = 0; p_stray = 0; p_oready = 0; fix_delay = 3; p_ready = 100;
        repeat (6) step();
        redir_mode = 1; have_pc = 1; forced_pc = 32'h80;
        wait_redir("pre_reset_redir");
        #3 rst = 1;
        #1 check_reset_outputs("async");
        model_reset();
        ifc.imem_rvalid = 1;
        ifc.imem_rdata  = $urandom;
        @(posedge clk); #1;
        check_reset_outputs("held");
        rst = 0;
        p_stray = 100; p_oready = 100; fix_delay = 1;
        wait_hs("post_reset_addr", RESET_PC);
        p_stray = 0;
        repeat (20) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
